repeat_accumulate_buffer: RTL

//  Consumer-side dual of the replaying input buffer: receives REPEAT passes of BUFFER_SIZE beats
//  and sums each element across passes. During passes 0..REPEAT-2 beats are absorbed into local

---
 rtl/mase_buffer_pkg.sv | 17 +
 rtl/repeat_accumulate_buffer_accum_lane.sv | 26 ++
 rtl/repeat_accumulate_buffer.sv | 107 ++++++++++
 3 files changed

// File: rtl/mase_buffer_pkg.sv
// Shared types and helpers for the MASE streaming buffers.
// Pure declarations: no latency and no backpressure of its own.
package mase_buffer_pkg;

  typedef enum logic [1:0] {FIRST, ACCUM, LAST} pass_e;

  localparam int SEXT_MAX_W = 64;

  // Sign-extend v from bit top_bit upward across the full helper width.
  function automatic logic [SEXT_MAX_W-1:0] sext_to(input logic [SEXT_MAX_W-1:0] v,
                                                    input logic [5:0]            top_bit);
    logic [SEXT_MAX_W-1:0] mask;
    mask = {SEXT_MAX_W{1'b1}} << top_bit;
    return v[top_bit] ? (v | mask) : (v & ~mask);
  endfunction

endpackage

// File: rtl/repeat_accumulate_buffer_accum_lane.sv
// One element lane: sign-extend the input, then either load it or add it to the stored sum.
// Purely combinational, 0-cycle latency; backpressure is handled by the parent.
module accum_lane
  import mase_buffer_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 34
) (
  input  logic [IN_WIDTH-1:0]  din_i,
  input  logic [OUT_WIDTH-1:0] acc_i,
  input  logic                 first_i,
  output logic [OUT_WIDTH-1:0] sum_o
);

  logic [SEXT_MAX_W-1:0]           din_wide;
  logic [SEXT_MAX_W-1:0]           din_ext;
  logic [SEXT_MAX_W-OUT_WIDTH-1:0] unused_ext_hi;

  assign din_wide      = SEXT_MAX_W'(din_i);
  assign din_ext       = sext_to(din_wide, 6'(IN_WIDTH - 1));
  assign unused_ext_hi = din_ext[SEXT_MAX_W-1:OUT_WIDTH];

  // On the first pass the stored value is stale, so it is ignored rather than added.
  assign sum_o = first_i ? din_ext[OUT_WIDTH-1:0] : acc_i + din_ext[OUT_WIDTH-1:0];

endmodule

// File: rtl/repeat_accumulate_buffer.sv
// Sums REPEAT passes of BUFFER_SIZE beats element-wise; the last pass streams out as storage+input.
// Absorbing passes never stall; last pass is 0-cycle pass-through with ready/valid forwarded.
module repeat_accumulate_buffer
  import mase_buffer_pkg::*;
#(
  parameter int IN_WIDTH       = 32,
  parameter int IN_PARALLELISM = 4,
  parameter int IN_SIZE        = 4,
  parameter int BUFFER_SIZE    = 4,
  parameter int REPEAT         = 4
) (
  input  logic                                                          clk,
  input  logic                                                          rst,
  input  logic [IN_PARALLELISM*IN_SIZE*IN_WIDTH-1:0]                    data_in,
  input  logic                                                          data_in_valid,
  output logic                                                          data_in_ready,
  output logic [IN_PARALLELISM*IN_SIZE*(IN_WIDTH+$clog2(REPEAT))-1:0]  data_out,
  output logic                                                          data_out_valid,
  input  logic                                                          data_out_ready
);

  localparam int E         = IN_PARALLELISM * IN_SIZE;
  localparam int OUT_WIDTH = IN_WIDTH + $clog2(REPEAT);
  localparam int ADDR_W    = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam int PASS_W    = (REPEAT > 1) ? $clog2(REPEAT) : 1;

  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [PASS_W-1:0]    pass_q, pass_d;
  pass_e                pass_type;
  logic                 in_hs;
  logic                 first_pass;
  logic [OUT_WIDTH-1:0] store_q  [BUFFER_SIZE][E];
  logic [OUT_WIDTH-1:0] lane_sum [E];

  // With REPEAT==1 the LAST check wins, and first_pass makes the lanes ignore storage.
  always_comb begin
    pass_type = ACCUM;
    if (pass_q == PASS_W'(REPEAT - 1)) begin
      pass_type = LAST;
    end else if (pass_q == '0) begin
      pass_type = FIRST;
    end
  end

  assign first_pass = (pass_q == '0);

  always_comb begin
    data_in_ready  = 1'b0;
    data_out_valid = 1'b0;
    if (!rst) begin
      if (pass_type == LAST) begin
        data_in_ready  = data_out_ready;
        data_out_valid = data_in_valid;
      end else begin
        data_in_ready  = 1'b1;
      end
    end
  end

  assign in_hs = data_in_valid & data_in_ready;

  always_comb begin
    addr_d = addr_q;
    pass_d = pass_q;
    if (in_hs) begin
      if (addr_q == ADDR_W'(BUFFER_SIZE - 1)) begin
        addr_d = '0;
        pass_d = (pass_q == PASS_W'(REPEAT - 1)) ? '0 : pass_q + PASS_W'(1);
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      pass_q <= '0;
    end else begin
      addr_q <= addr_d;
      pass_q <= pass_d;
    end
  end

  for (genvar g = 0; g < E; g++) begin : g_lane
    accum_lane #(
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH)
    ) u_lane (
      .din_i   (data_in[g*IN_WIDTH +: IN_WIDTH]),
      .acc_i   (store_q[addr_q][g]),
      .first_i (first_pass),
      .sum_o   (lane_sum[g])
    );
    assign data_out[g*OUT_WIDTH +: OUT_WIDTH] = lane_sum[g];
  end

  // Storage is left unreset on purpose: the first pass always overwrites it.
  always_ff @(posedge clk) begin
    if (in_hs && pass_type != LAST) begin
      for (int i = 0; i < E; i++) begin
        store_q[addr_q][i] <= lane_sum[i];
      end
    end
  end

endmodule
